// File: rtl/fpga_rst_seq.sv
// Board reset conditioner: button sync/debounce, pulse stretch and
// staggered per-channel reset release, ch0 first.
module fpga_rst_seq #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STRETCH_CYCLES  = 8,
  parameter int NUM_CH          = 2,
  parameter int STAGGER_CYCLES  = 4,
  parameter int BTN_ACTIVE_HIGH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_raw,
  output logic [NUM_CH-1:0] rst_out,
  output logic              rst_done,
  output logic              btn_event
);

  localparam int LAST    = STAGGER_CYCLES * (NUM_CH - 1);
  localparam int CNT_MAX = (STRETCH_CYCLES > LAST) ?
                           STRETCH_CYCLES : LAST;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    HOLD, STRETCH, RELEASE, IDLE
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_n;
  logic                   synced;
  logic                   deb_q, deb_d;
  logic [DW-1:0]          db_cnt_q, db_cnt_d;
  logic                   event_d;
  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_CH-1:0]      rst_out_q, rst_out_d;
  logic                   rst_done_q, rst_done_d;
  logic                   btn_event_q;

  assign btn_n  = (BTN_ACTIVE_HIGH != 0) ? btn_raw : ~btn_raw;
  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = '0;
    if (synced != deb_q) begin
      if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = synced;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign event_d = deb_d & ~deb_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (deb_q) begin
      state_d = HOLD;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        HOLD: begin
          state_d = STRETCH;
          cnt_d   = '0;
        end
        STRETCH: begin
          if (cnt_q == CW'(STRETCH_CYCLES - 1)) begin
            cnt_d   = '0;
            state_d = (LAST == 0) ? IDLE : RELEASE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(LAST)) state_d = IDLE;
        end
        IDLE: begin
          cnt_d = cnt_q;
        end
        default: begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Channel k drops once the release counter reaches k*STAGGER.
  always_comb begin
    rst_out_d = '1;
    unique case (state_d)
      RELEASE: begin
        for (int k = 0; k < NUM_CH; k++) begin
          rst_out_d[k] = (STAGGER_CYCLES * k) > int'(cnt_d);
        end
      end
      IDLE:    rst_out_d = '0;
      default: rst_out_d = '1;
    endcase
    rst_done_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      deb_q       <= 1'b0;
      db_cnt_q    <= '0;
      state_q     <= STRETCH;
      cnt_q       <= '0;
      rst_out_q   <= '1;
      rst_done_q  <= 1'b0;
      btn_event_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], btn_n};
      deb_q       <= deb_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rst_out_q   <= rst_out_d;
      rst_done_q  <= rst_done_d;
      btn_event_q <= event_d;
    end
  end

  assign rst_out   = rst_out_q;
  assign rst_done  = rst_done_q;
  assign btn_event = btn_event_q;

endmodule

// File: tb/tb_fpga_rst_seq.sv
// Bench for fpga_rst_seq: vector table, directed corner sequences and
// random button/reset traffic against a timestamp-based reference model.
module tb_fpga_rst_seq;

  localparam int SYNC    = 2;
  localparam int DEB     = 16;
  localparam int STRETCH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       btn = 1'b0;
  logic       btn_a_raw, btn_b_raw;
  logic [1:0] out_a;
  logic [3:0] out_b;
  logic [2:0] out_c;
  logic       done_a, done_b, done_c;
  logic       ev_a, ev_b, ev_c;

  assign btn_a_raw = btn;
  assign btn_b_raw = ~btn;

  fpga_rst_seq dut_a (
    .clk(clk), .rst(rst), .btn_raw(btn_a_raw),
    .rst_out(out_a), .rst_done(done_a), .btn_event(ev_a)
  );

  fpga_rst_seq #(
    .NUM_CH(4), .STAGGER_CYCLES(0), .BTN_ACTIVE_HIGH(0)
  ) dut_b (
    .clk(clk), .rst(rst), .btn_raw(btn_b_raw),
    .rst_out(out_b), .rst_done(done_b), .btn_event(ev_b)
  );

  fpga_rst_seq #(
    .NUM_CH(3), .STAGGER_CYCLES(30)
  ) dut_c (
    .clk(clk), .rst(rst), .btn_raw(btn_a_raw),
    .rst_out(out_c), .rst_done(done_c), .btn_event(ev_c)
  );

  int checks = 0;
  int fails  = 0;

  // Model: each sequence has a start edge t0; channel k is released
  // at t0 + STRETCH + k*stagger unless the button holds everything.
  int n        = 0;
  int last_rst = 0;
  int run      = 0;
  int t0       = 0;
  bit deb      = 1'b0;
  bit hold     = 1'b0;
  bit ev_m     = 1'b0;
  bit hist [0:16383];

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @tick %0d: got %h expected %h", nm, n, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_bits(int nch, int stag);
    logic [3:0] v;
    v = '0;
    for (int k = 0; k < nch; k++) begin
      v[k] = hold ? 1'b1 : (n < t0 + STRETCH + stag * k);
    end
    return v;
  endfunction

  task automatic tick();
    bit syn, dprev;
    logic [3:0] ea, eb, ec;
    @(posedge clk);
    @(negedge clk);
    n++;
    hist[n] = btn;
    if (rst) begin
      last_rst = n;
      deb = 1'b0; run = 0; hold = 1'b0; t0 = n; ev_m = 1'b0;
    end else begin
      syn = 1'b0;
      if (n - SYNC > last_rst) syn = hist[n-SYNC];
      dprev = deb;
      if (syn != deb) begin
        run++;
        if (run == DEB) begin
          deb = ~deb;
          run = 0;
        end
      end else begin
        run = 0;
      end
      ev_m = deb & ~dprev;
      if (dprev) hold = 1'b1;
      else if (hold) begin
        hold = 1'b0;
        t0   = n;
      end
    end
    ea = exp_bits(2, 4);
    eb = exp_bits(4, 0);
    ec = exp_bits(3, 30);
    chk("model_a", 8'({out_a, done_a, ev_a}),
        8'({ea[1:0], ea == 4'd0, ev_m}));
    chk("model_b", 8'({out_b, done_b, ev_b}),
        8'({eb, eb == 4'd0, ev_m}));
    chk("model_c", 8'({out_c, done_c, ev_c}),
        8'({ec[2:0], ec == 4'd0, ev_m}));
  endtask

  task automatic wait_ev_c(int lim, string nm);
    int k = 0;
    while (ev_c !== 1'b1 && k < lim) begin
      tick();
      k++;
    end
    checks++;
    if (ev_c !== 1'b1) begin
      fails++;
      $display("FAIL %s: btn_event got %b required 1 within %0d", nm, ev_c, lim);
    end
  endtask

  task automatic wait_out_c(logic [2:0] v, int lim, string nm);
    int k = 0;
    while (out_c !== v && k < lim) begin
      tick();
      k++;
    end
    checks++;
    if (out_c !== v) begin
      fails++;
      $display("FAIL %s: rst_out got %b required %b", nm, out_c, v);
    end
  endtask

  typedef struct {
    bit         r;
    bit         b;
    int         cyc;
    logic [1:0] oa;
    bit         da;
    bit         ea;
    logic [3:0] ob;
  } vec_t;

  vec_t tbl [16];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 5,  2'b11, 1'b0, 1'b0, 4'hF};
    tbl[1]  = '{1'b0, 1'b0, 7,  2'b11, 1'b0, 1'b0, 4'hF};
    tbl[2]  = '{1'b0, 1'b0, 1,  2'b10, 1'b0, 1'b0, 4'h0};
    tbl[3]  = '{1'b0, 1'b0, 3,  2'b10, 1'b0, 1'b0, 4'h0};
    tbl[4]  = '{1'b0, 1'b0, 1,  2'b00, 1'b1, 1'b0, 4'h0};
    tbl[5]  = '{1'b0, 1'b0, 20, 2'b00, 1'b1, 1'b0, 4'h0};
    tbl[6]  = '{1'b0, 1'b1, 10, 2'b00, 1'b1, 1'b0, 4'h0};
    tbl[7]  = '{1'b0, 1'b0, 30, 2'b00, 1'b1, 1'b0, 4'h0};
    tbl[8]  = '{1'b0, 1'b1, 17, 2'b00, 1'b1, 1'b0, 4'h0};
    tbl[9]  = '{1'b0, 1'b1, 1,  2'b00, 1'b1, 1'b1, 4'h0};
    tbl[10] = '{1'b0, 1'b1, 1,  2'b11, 1'b0, 1'b0, 4'hF};
    tbl[11] = '{1'b0, 1'b1, 21, 2'b11, 1'b0, 1'b0, 4'hF};
    tbl[12] = '{1'b0, 1'b0, 26, 2'b11, 1'b0, 1'b0, 4'hF};
    tbl[13] = '{1'b0, 1'b0, 1,  2'b10, 1'b0, 1'b0, 4'h0};
    tbl[14] = '{1'b0, 1'b0, 3,  2'b10, 1'b0, 1'b0, 4'h0};
    tbl[15] = '{1'b0, 1'b0, 1,  2'b00, 1'b1, 1'b0, 4'h0};

    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].r;
      btn = tbl[i].b;
      repeat (tbl[i].cyc) tick();
      chk($sformatf("tbl%0d_out", i), 8'(out_a), 8'(tbl[i].oa));
      chk($sformatf("tbl%0d_done", i), 8'(done_a), 8'(tbl[i].da));
      chk($sformatf("tbl%0d_ev", i), 8'(ev_a), 8'(tbl[i].ea));
      chk($sformatf("tbl%0d_outb", i), 8'(out_b), 8'(tbl[i].ob));
      chk($sformatf("tbl%0d_doneb", i), 8'(done_b),
          8'(tbl[i].ob == 4'h0));
    end

    // Re-press while the long-stagger instance is mid-release.
    repeat (70) tick();
    btn = 1'b1;
    wait_ev_c(40, "s4_ev1");
    tick();
    chk("s4_hold", 8'({out_c, done_c}), 8'({3'b111, 1'b0}));
    btn = 1'b0;
    wait_out_c(3'b110, 60, "s4_rel0");
    btn = 1'b1;
    wait_ev_c(40, "s4_ev2");
    chk("s4_mid", 8'(out_c), 8'(3'b110));
    tick();
    chk("s4_reassert", 8'({out_c, done_c}), 8'({3'b111, 1'b0}));
    btn = 1'b0;
    repeat (120) tick();
    chk("s4_final", 8'({out_c, done_c}), 8'({3'b000, 1'b1}));

    // rst during STRETCH, then during HOLD with the button held.
    rst = 1'b1; repeat (2) tick();
    rst = 1'b0; repeat (3) tick();
    rst = 1'b1; tick();
    chk("s5_stretch", 8'({out_a, done_a, ev_a}), 8'({2'b11, 2'b00}));
    rst = 1'b0; repeat (7) tick();
    chk("s5_pre", 8'(out_a), 8'(2'b11));
    tick();
    chk("s5_rel0", 8'(out_a), 8'(2'b10));
    btn = 1'b1; repeat (25) tick();
    rst = 1'b1; tick();
    chk("s5_hold", 8'({out_a, done_a, ev_a}), 8'({2'b11, 2'b00}));
    rst = 1'b0; repeat (40) tick();
    btn = 1'b0; repeat (120) tick();
    chk("s5_final", 8'({out_a, done_a}), 8'({2'b00, 1'b1}));

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 3)) tick();
        rst = 1'b0;
      end
      btn = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 40)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
